rr_vc_arbiter: RTL and testbench

RR_VC_ARBITER -- requirements
Module: rr_vc_arbiter

---
 rtl/rr_vc_arbiter_if.sv | 13 +
 rtl/rr_vc_arbiter.sv | 61 ++++++
 tb/tb_rr_vc_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/rr_vc_arbiter_if.sv
// rr_vc_arbiter_if: request/grant and statistics signals between input ports and the VC arbiter.
interface rr_vc_arbiter_if #(parameter int CNT_W = 16);
  logic             polarity;
  logic [4:0]       req;
  logic             empty;
  logic [4:0]       grant;
  logic             grant_valid;
  logic [2:0]       grant_idx;
  logic [2:0]       stat_sel;
  logic [CNT_W-1:0] stat_cnt;
  modport master (output polarity, req, empty, stat_sel, input grant, grant_valid, grant_idx, stat_cnt);
  modport slave  (input polarity, req, empty, stat_sel, output grant, grant_valid, grant_idx, stat_cnt);
endinterface

// File: rtl/rr_vc_arbiter.sv
// rr_vc_arbiter: five-port round-robin arbiter with independent even/odd VC pointers.
// Define ARB_STATS_EN to add saturating per-port grant counters readable via stat_sel/stat_cnt.
module rr_vc_arbiter #(
  parameter int CNT_W = 16
) (
  input logic            clk,
  input logic            reset,
  rr_vc_arbiter_if.slave s
);
  logic [2:0] ptr_even_q, ptr_even_d, ptr_odd_q, ptr_odd_d;
  logic [2:0] ptr_raw, ptr_act, ptr_nxt, idx, gnt_idx;
  logic [3:0] sum;
  logic       gnt_vld;
  logic [4:0] gnt;
  always_comb begin
    ptr_raw = s.polarity ? ptr_odd_q : ptr_even_q;
    ptr_act = ptr_raw > 3'd4 ? 3'd0 : ptr_raw;
    gnt_idx = 3'd0;
    gnt_vld = 1'b0;
    sum     = 4'd0;
    idx     = 3'd0;
    // scan from farthest to nearest so the nearest requester wins
    for (int k = 4; k >= 0; k--) begin
      sum = {1'b0, ptr_act} + 4'(k);
      idx = sum > 4'd4 ? 3'(sum - 4'd5) : sum[2:0];
      if (s.req[idx]) begin
        gnt_idx = idx;
        gnt_vld = 1'b1;
      end
    end
    gnt_vld    = gnt_vld & s.empty & ~reset;
    gnt_idx    = gnt_vld ? gnt_idx : 3'd0;
    gnt        = gnt_vld ? 5'b00001 << gnt_idx : 5'b00000;
    ptr_nxt    = gnt_idx == 3'd4 ? 3'd0 : gnt_idx + 3'd1;
    ptr_even_d = reset ? 3'd0 : (gnt_vld && !s.polarity) ? ptr_nxt : ptr_even_q;
    ptr_odd_d  = reset ? 3'd0 : (gnt_vld && s.polarity) ? ptr_nxt : ptr_odd_q;
  end
  always_ff @(posedge clk) begin
    ptr_even_q <= ptr_even_d;
    ptr_odd_q  <= ptr_odd_d;
  end
  assign s.grant       = gnt;
  assign s.grant_valid = gnt_vld;
  assign s.grant_idx   = gnt_idx;
`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q [5];
  logic [CNT_W-1:0] cnt_d [5];
  always_comb begin
    for (int i = 0; i < 5; i++)
      cnt_d[i] = reset ? '0 : (gnt[i] && cnt_q[i] != '1) ? cnt_q[i] + 1'b1 : cnt_q[i];
  end
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end
  assign s.stat_cnt = s.stat_sel > 3'd4 ? '0 : cnt_q[s.stat_sel];
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^s.stat_sel;
  assign s.stat_cnt      = '0;
`endif
endmodule

// File: tb/tb_rr_vc_arbiter.sv
// tb_rr_vc_arbiter: directed vectors for the even/odd round-robin arbiter and its optional statistics.
module tb_rr_vc_arbiter;
  localparam int CNT_W = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  rr_vc_arbiter_if #(.CNT_W(CNT_W)) bus ();
  rr_vc_arbiter #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .s(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [2:0] enc(input logic [4:0] g);
    enc = 3'd0;
    for (int i = 0; i < 5; i++) if (g[i]) enc = 3'(i);
  endfunction
  task automatic cyc(input logic rst, input logic p, input logic [4:0] r, input logic e,
                     input logic [4:0] exp_g, input string tag);
    reset = rst;
    bus.polarity = p;
    bus.req = r;
    bus.empty = e;
    @(negedge clk);
    check({tag, ".grant"}, 32'(bus.grant), 32'(exp_g));
    check({tag, ".valid"}, 32'(bus.grant_valid), 32'(|exp_g));
    check({tag, ".idx"}, 32'(bus.grant_idx), 32'(enc(exp_g)));
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [CNT_W-1:0] exp_sat;
`ifdef ARB_STATS_EN
    exp_sat = '1;
`else
    exp_sat = '0;
`endif
    bus.polarity = 1'b0;
    bus.req = 5'b11111;
    bus.empty = 1'b1;
    bus.stat_sel = 3'd2;
    @(posedge clk);
    #1;
    cyc(1, 0, 5'b11111, 1, 5'b00000, "rst_hold0");
    cyc(1, 1, 5'b11111, 1, 5'b00000, "rst_hold1");
    check("rst_stat", 32'(bus.stat_cnt), 32'd0);
    // all five requesting on even: full rotation then back to port 0
    cyc(0, 0, 5'b11111, 1, 5'b00001, "rr0");
    cyc(0, 0, 5'b11111, 1, 5'b00010, "rr1");
    cyc(0, 0, 5'b11111, 1, 5'b00100, "rr2");
    cyc(0, 0, 5'b11111, 1, 5'b01000, "rr3");
    cyc(0, 0, 5'b11111, 1, 5'b10000, "rr4");
    cyc(0, 0, 5'b11111, 1, 5'b00001, "rr_wrap");
    // even ptr=1, odd ptr=0; alternating polarity with S and W requesting
    cyc(0, 0, 5'b10010, 1, 5'b00010, "alt_e0");
    cyc(0, 1, 5'b10010, 1, 5'b00010, "alt_o0");
    cyc(0, 0, 5'b10010, 1, 5'b10000, "alt_e1");
    cyc(0, 1, 5'b10010, 1, 5'b10000, "alt_o1");
    cyc(0, 0, 5'b10010, 1, 5'b00010, "alt_e2");
    cyc(0, 1, 5'b10010, 1, 5'b00010, "alt_o2");
    // stall: pointers reset to 0, hold through empty=0
    cyc(1, 0, 5'b11111, 1, 5'b00000, "rst_mid");
    cyc(0, 0, 5'b11111, 0, 5'b00000, "stall0");
    cyc(0, 0, 5'b11111, 0, 5'b00000, "stall1");
    cyc(0, 0, 5'b11111, 0, 5'b00000, "stall2");
    cyc(0, 0, 5'b11111, 1, 5'b00001, "stall_end");
    cyc(0, 1, 5'b11111, 1, 5'b00001, "stall_odd");
    cyc(0, 0, 5'b00000, 1, 5'b00000, "no_req");
    // walk even ptr from 1 to 4, then wrap with req=00011
    cyc(0, 0, 5'b11111, 1, 5'b00010, "walk1");
    cyc(0, 0, 5'b11111, 1, 5'b00100, "walk2");
    cyc(0, 0, 5'b11111, 1, 5'b01000, "walk3");
    cyc(0, 0, 5'b00011, 1, 5'b00001, "wrap4");
    cyc(0, 0, 5'b00011, 1, 5'b00010, "wrap_next");
    // odd ptr from 1 to 3, then a one-cycle reset
    cyc(0, 1, 5'b11111, 1, 5'b00010, "odd1");
    cyc(0, 1, 5'b11111, 1, 5'b00100, "odd2");
    cyc(1, 1, 5'b11111, 1, 5'b00000, "odd_rst");
    cyc(0, 1, 5'b11111, 1, 5'b00001, "odd_after");
    cyc(0, 0, 5'b11111, 1, 5'b00001, "even_after");
    // single requester N granted every cycle; counter saturates at 15
    cyc(1, 0, 5'b00000, 1, 5'b00000, "rst_stats");
    check("stat_clr", 32'(bus.stat_cnt), 32'd0);
    for (int i = 0; i < 20; i++) begin
      cyc(0, i[0], 5'b00100, 1, 5'b00100, $sformatf("single%0d", i));
      if (i == 9) check("stat_mid", 32'(bus.stat_cnt), exp_sat == '0 ? 32'd0 : 32'd10);
    end
    check("stat_sat", 32'(bus.stat_cnt), 32'(exp_sat));
    bus.stat_sel = 3'd0;
    #1;
    check("stat_p0", 32'(bus.stat_cnt), 32'd0);
    bus.stat_sel = 3'd5;
    #1;
    check("stat_sel5", 32'(bus.stat_cnt), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
